// File: rtl/rv32_alu_issue.sv
// rv32_alu_issue: S1 issue register drives rv32_alu combinationally, S2 captures result/branch; S2->S1 bypass with RV32_ALU_ISSUE_FWD_EN.
// Latency: accept at edge N, result valid after edge N+1; one instruction per cycle, no bubbles.
// Backpressure: out_valid && !out_ready freezes S2, S1 and the alu_* drive; in_ready drops once both stages are full.
`ifndef RV32_DEFINES_SVH
`define RV32_DEFINES_SVH
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_EQ   4'd10
`define ALU_NEQ  4'd11
`define ALU_SBT  4'd12
`define ALU_SBTU 4'd13
typedef logic [3:0] rv32_alu_op_t;
`endif

module rv32_alu_issue #(
    parameter int XLEN   = 32,
    parameter int PC_INC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1_idx,
    input  logic [4:0]      in_rs2_idx,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output rv32_alu_op_t    alu_opcode,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_wb_en,
    output logic [XLEN-1:0] out_wb_data,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_br_target,
    output logic            out_illegal
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7_5;
        logic [4:0]      rd;
        logic [4:0]      rs1_idx;
        logic [4:0]      rs2_idx;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } s1_t;

    s1_t             s1;
    logic            s1_valid;
    logic            s2_take;
    logic [XLEN-1:0] rs1_eff;
    logic [XLEN-1:0] rs2_eff;
    logic [XLEN-1:0] tgt_sum;
    logic [XLEN-1:0] tgt;
    logic            wb_req;
    logic            br_cond;
    logic            br_jump;
    logic            br_req;
    logic            illegal;
    logic            is_jalr;

    assign s2_take  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_take;

    function automatic rv32_alu_op_t arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? `ALU_SUB : `ALU_ADD;
            3'b001:  arith_op = `ALU_SLL;
            3'b010:  arith_op = `ALU_SLT;
            3'b011:  arith_op = `ALU_SLTU;
            3'b100:  arith_op = `ALU_XOR;
            3'b101:  arith_op = alt ? `ALU_SRA : `ALU_SRL;
            3'b110:  arith_op = `ALU_OR;
            default: arith_op = `ALU_AND;
        endcase
    endfunction

    // Register values as seen by S1, optionally patched with the result waiting in S2.
    always_comb begin
        rs1_eff = s1.rs1_val;
        rs2_eff = s1.rs2_val;
`ifdef RV32_ALU_ISSUE_FWD_EN
        if (out_valid && out_wb_en && out_rd != 5'd0 && out_rd == s1.rs1_idx)
            rs1_eff = out_wb_data;
        if (out_valid && out_wb_en && out_rd != 5'd0 && out_rd == s1.rs2_idx)
            rs2_eff = out_wb_data;
`endif
    end

`ifndef RV32_ALU_ISSUE_FWD_EN
    logic unused_idx;
    assign unused_idx = ^{s1.rs1_idx, s1.rs2_idx};
`endif

    always_comb begin
        alu_rs1    = '0;
        alu_rs2    = '0;
        alu_opcode = `ALU_ADD;
        wb_req     = 1'b0;
        br_cond    = 1'b0;
        br_jump    = 1'b0;
        illegal    = 1'b0;
        is_jalr    = 1'b0;
        if (s1_valid) begin
            case (s1.opcode)
                OPC_OP: begin
                    alu_rs1    = rs1_eff;
                    alu_rs2    = rs2_eff;
                    alu_opcode = arith_op(s1.funct3, s1.funct7_5);
                    wb_req     = 1'b1;
                end
                OPC_OPIMM: begin
                    alu_rs1    = rs1_eff;
                    alu_rs2    = s1.imm;
                    alu_opcode = arith_op(s1.funct3, s1.funct7_5 && s1.funct3 == 3'b101);
                    wb_req     = 1'b1;
                end
                OPC_LUI: begin
                    alu_rs2 = s1.imm;
                    wb_req  = 1'b1;
                end
                OPC_AUIPC: begin
                    alu_rs1 = s1.pc;
                    alu_rs2 = s1.imm;
                    wb_req  = 1'b1;
                end
                OPC_BRANCH: begin
                    alu_rs1 = rs1_eff;
                    alu_rs2 = rs2_eff;
                    br_cond = 1'b1;
                    case (s1.funct3)
                        3'b000:  alu_opcode = `ALU_EQ;
                        3'b001:  alu_opcode = `ALU_NEQ;
                        3'b100:  alu_opcode = `ALU_SLT;
                        3'b101:  alu_opcode = `ALU_SBT;
                        3'b110:  alu_opcode = `ALU_SLTU;
                        3'b111:  alu_opcode = `ALU_SBTU;
                        default: begin
                            illegal = 1'b1;
                            br_cond = 1'b0;
                        end
                    endcase
                end
                OPC_JAL, OPC_JALR: begin
                    alu_rs1 = s1.pc;
                    alu_rs2 = XLEN'(PC_INC);
                    wb_req  = 1'b1;
                    br_jump = 1'b1;
                    is_jalr = (s1.opcode == OPC_JALR);
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    // Kept apart from decode so alu_z never feeds back into the ALU drive.
    assign br_req  = br_jump || (br_cond && !alu_z);
    assign tgt_sum = (is_jalr ? rs1_eff : s1.pc) + s1.imm;
    assign tgt     = is_jalr ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid      <= 1'b0;
            out_valid     <= 1'b0;
            out_rd        <= '0;
            out_wb_en     <= 1'b0;
            out_wb_data   <= '0;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
            out_illegal   <= 1'b0;
        end else begin
            if (in_valid && in_ready)
                s1_valid <= 1'b1;
            else if (s2_take)
                s1_valid <= 1'b0;
            if (s2_take) begin
                out_valid     <= 1'b1;
                out_rd        <= s1.rd;
                out_wb_en     <= wb_req && (s1.rd != 5'd0);
                out_wb_data   <= alu_res;
                out_br_taken  <= br_req;
                out_br_target <= tgt;
                out_illegal   <= illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            s1 <= '{opcode: in_opcode, funct3: in_funct3, funct7_5: in_funct7_5, rd: in_rd,
                    rs1_idx: in_rs1_idx, rs2_idx: in_rs2_idx, rs1_val: in_rs1_val,
                    rs2_val: in_rs2_val, imm: in_imm, pc: in_pc};
    end
endmodule
